// File: rtl/tinyriscv_pkg.sv
// Types shared by the tinyriscv front end: fetch FSM states and FIFO entry layout.
package tinyriscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a single-cycle flush.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = CW'(wptr - rptr);
  assign rdata   = mem[rptr[AW-1:0]];
  // Pop before push lets a full FIFO accept a write in the same cycle it is read.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: pipelined req/gnt/rvalid fetches into a small FIFO,
// with flush-time discard of stale responses and halt on bus error.
module ifu_prefetch
  import tinyriscv_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        id_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  output logic        inst_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e  state_q;
  logic          req_q, pend_kill_q, err_seen_q;
  logic [31:0]   fetch_pc_q, addr_q, resp_pc_q, flush_pc;
  logic [OW-1:0] live_q, kill_q, live_nxt, kill_nxt;
  logic [CW-1:0] fifo_count, count_nxt;
  logic          fifo_full, fifo_empty;
  logic          granted, drop, push, pop, err_push, credit_nxt;
  fetch_entry_t  head, wentry;

  assign flush_pc = {flush_addr_i[31:2], 2'b00};
  assign granted  = req_q && instr_gnt_i;
  assign drop     = instr_rvalid_i && (kill_q != '0);
  assign push     = instr_rvalid_i && (kill_q == '0) && !flush_i;
  assign pop      = !fifo_empty && id_ready_i && !flush_i;
  assign err_push = push && instr_err_i;
  assign wentry   = '{err: instr_err_i, pc: resp_pc_q, inst: instr_rdata_i};

  sync_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush_i),
    .wdata (wentry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .rdata (head)
  );

  // Credit is judged on next-cycle occupancy so a grant and a response in the
  // same cycle still allow back-to-back issue.
  always_comb begin
    live_nxt  = live_q;
    kill_nxt  = kill_q;
    count_nxt = fifo_count;
    if (flush_i) begin
      live_nxt  = '0;
      kill_nxt  = kill_q + live_q + OW'(granted) - OW'(instr_rvalid_i);
      count_nxt = '0;
    end else begin
      if (granted) begin
        if (pend_kill_q) kill_nxt = kill_nxt + OW'(1);
        else             live_nxt = live_nxt + OW'(1);
      end
      if (drop)                   kill_nxt = kill_nxt - OW'(1);
      if (instr_rvalid_i && !drop) live_nxt = live_nxt - OW'(1);
      count_nxt = fifo_count + CW'(push) - CW'(pop);
    end
    credit_nxt = (32'(live_nxt) + 32'(kill_nxt) < 32'(MAX_OUTSTANDING)) &&
                 (32'(count_nxt) + 32'(live_nxt) < 32'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      live_q      <= '0;
      kill_q      <= '0;
      pend_kill_q <= 1'b0;
      err_seen_q  <= 1'b0;
    end else begin
      live_q <= live_nxt;
      kill_q <= kill_nxt;
      if (push) resp_pc_q <= resp_pc_q + 32'd4;
      if (flush_i) begin
        fetch_pc_q <= flush_pc;
        resp_pc_q  <= flush_pc;
        err_seen_q <= 1'b0;
        if (req_q && !instr_gnt_i) begin
          // Request cannot be withdrawn; it completes later as a killed transaction.
          pend_kill_q <= 1'b1;
        end else begin
          pend_kill_q <= 1'b0;
          if (credit_nxt) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= flush_pc;
          end else begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (err_push) begin
              state_q <= HALT;
            end else if (credit_nxt) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= fetch_pc_q;
            end
          end
          REQ: begin
            if (instr_gnt_i) begin
              pend_kill_q <= 1'b0;
              if (!pend_kill_q) fetch_pc_q <= fetch_pc_q + 32'd4;
              if (err_push || err_seen_q) begin
                state_q    <= HALT;
                req_q      <= 1'b0;
                err_seen_q <= 1'b0;
              end else if (credit_nxt) begin
                addr_q <= pend_kill_q ? fetch_pc_q : fetch_pc_q + 32'd4;
              end else begin
                state_q <= IDLE;
                req_q   <= 1'b0;
              end
            end else if (err_push) begin
              err_seen_q <= 1'b1;
            end
          end
          HALT: state_q <= HALT;
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign instr_req_o  = req_q;
  assign instr_addr_o = addr_q;
  assign inst_valid_o = !fifo_empty;
  assign inst_err_o   = !fifo_empty && head.err;
  assign inst_o       = fifo_empty ? 32'd0 : head.inst;
  assign pc_o         = fifo_empty ? resp_pc_q : head.pc;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && live_q == '0 && kill_q == '0));

endmodule
